// File: rtl/alu_pkg.sv
// alu_pkg: ALU opcode constants and arbiter state encoding
package alu_pkg;
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_MUL = 2'b01;
  localparam logic [1:0] OP_DIV = 2'b10;
  localparam logic [1:0] OP_CMP = 2'b11;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker, first set request searching upward from ptr_i with wrap
module rr_pick #(
  parameter int N_REQ = 2,
  parameter int IW    = 1
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IW-1:0]    ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [IW-1:0]    idx_o
);
  logic [IW:0]   j;
  logic [IW-1:0] k;
  logic          found;
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    j     = '0;
    k     = '0;
    for (int i = 0; i < N_REQ; i++) begin
      j = {1'b0, ptr_i} + (IW+1)'(i);
      k = j >= (IW+1)'(N_REQ) ? IW'(j - (IW+1)'(N_REQ)) : IW'(j);
      if (!found && req_i[k]) begin
        found    = 1'b1;
        gnt_o[k] = 1'b1;
        idx_o    = k;
      end
    end
  end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one sequential ALU among N_REQ requesters round-robin,
// with a WAIT timeout that answers with an error if the ALU never finishes.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int TIMEOUT = 40,
  parameter int CW      = 6
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic [N_REQ-1:0]    req,
  input  logic [16*N_REQ-1:0] req_opA,
  input  logic [16*N_REQ-1:0] req_opB,
  input  logic [2*N_REQ-1:0]  req_opcode,
  output logic [N_REQ-1:0]    ack,
  output logic [N_REQ-1:0]    rsp_valid,
  output logic [31:0]         rsp_data,
  output logic                rsp_err,
  output logic                busy,
  output logic                alu_en,
  output logic [15:0]         alu_opA,
  output logic [15:0]         alu_opB,
  output logic [1:0]          alu_opcode,
  input  logic [31:0]         alu_res,
  input  logic                alu_done
);
  localparam int IW = N_REQ > 1 ? $clog2(N_REQ) : 1;
  state_t            state_q, state_d;
  logic [IW-1:0]     ptr_q, ptr_d, idx_q, idx_d, pick_idx;
  logic [N_REQ-1:0]  pick_gnt, ack_q, ack_d, rsp_valid_q, rsp_valid_d;
  logic [15:0]       opa_q, opa_d, opb_q, opb_d;
  logic [1:0]        opc_q, opc_d;
  logic [31:0]       data_q, data_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              err_q, err_d, en_q, en_d, first_q, first_d;
  rr_pick #(.N_REQ(N_REQ), .IW(IW)) u_pick (
    .req_i (req),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx)
  );
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    idx_d       = idx_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    opc_d       = opc_q;
    cnt_d       = cnt_q;
    first_d     = first_q;
    ack_d       = '0;
    rsp_valid_d = '0;
    data_d      = '0;
    err_d       = 1'b0;
    en_d        = 1'b0;
    unique case (state_q)
      IDLE: if (|req) begin
        state_d = ISSUE;
        idx_d   = pick_idx;
        ack_d   = pick_gnt;
        opa_d   = req_opA[{pick_idx, 4'b0} +: 16];
        opb_d   = req_opB[{pick_idx, 4'b0} +: 16];
        opc_d   = req_opcode[{pick_idx, 1'b0} +: 2];
      end
      ISSUE: begin
        state_d = WAIT;
        en_d    = 1'b1;
        cnt_d   = '0;
        first_d = 1'b1;
      end
      // done seen alongside our own en is left over from the previous command
      WAIT: if (first_q) first_d = 1'b0;
      else if (alu_done) begin
        state_d            = RESP;
        data_d             = alu_res;
        rsp_valid_d[idx_q] = 1'b1;
      end else if (cnt_q == CW'(TIMEOUT - 1)) begin
        state_d            = RESP;
        err_d              = 1'b1;
        rsp_valid_d[idx_q] = 1'b1;
      end else cnt_d = cnt_q + 1'b1;
      RESP: begin
        state_d = IDLE;
        ptr_d   = idx_q == IW'(N_REQ - 1) ? '0 : idx_q + 1'b1;
      end
    endcase
  end
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      idx_q       <= '0;
      opa_q       <= '0;
      opb_q       <= '0;
      opc_q       <= '0;
      cnt_q       <= '0;
      first_q     <= 1'b0;
      ack_q       <= '0;
      rsp_valid_q <= '0;
      data_q      <= '0;
      err_q       <= 1'b0;
      en_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      idx_q       <= idx_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      opc_q       <= opc_d;
      cnt_q       <= cnt_d;
      first_q     <= first_d;
      ack_q       <= ack_d;
      rsp_valid_q <= rsp_valid_d;
      data_q      <= data_d;
      err_q       <= err_d;
      en_q        <= en_d;
    end
  end
  assign ack        = ack_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = data_q;
  assign rsp_err    = err_q;
  assign busy       = state_q != IDLE;
  assign alu_en     = en_q;
  assign alu_opA    = opa_q;
  assign alu_opB    = opb_q;
  assign alu_opcode = opc_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed plus randomized checks of alu_arbiter against a round-robin reference model
module tb_alu_arbiter;
  import alu_pkg::*;
  localparam int N = 2, TO = 40;
  logic clk = 1'b0, nrst = 1'b0;
  logic [N-1:0] req = '0, keep = '0;
  logic [16*N-1:0] req_opA = '0, req_opB = '0;
  logic [2*N-1:0] req_opcode = '0;
  logic [N-1:0] ack, rsp_valid;
  logic [31:0] rsp_data, alu_res, pend;
  logic rsp_err, busy, alu_en, alu_done;
  logic [15:0] alu_opA, alu_opB;
  logic [1:0] alu_opcode;
  logic [15:0] opa_m [N], opb_m [N];
  logic [1:0] opc_m [N];
  int errors = 0, checks = 0, cyc = 0, ptr_m = 0;
  int lat = 1, span = 0, wcnt = 0, done_cyc = 0, n0 = 0;
  int ack_cyc[$], ack_idx[$], en_cyc[$], rsp_cyc[$], rsp_idx[$];
  logic [15:0] en_a[$], en_b[$];
  logic [1:0] en_op[$];
  logic [31:0] rsp_d[$];
  logic rsp_e[$];
  always #5 clk = ~clk;
  alu_arbiter #(.N_REQ(N), .TIMEOUT(TO), .CW(6)) dut (
    .clk(clk), .nrst(nrst), .req(req), .req_opA(req_opA), .req_opB(req_opB),
    .req_opcode(req_opcode), .ack(ack), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .busy(busy), .alu_en(alu_en), .alu_opA(alu_opA),
    .alu_opB(alu_opB), .alu_opcode(alu_opcode), .alu_res(alu_res), .alu_done(alu_done)
  );
  function automatic logic [31:0] ref_alu(logic [1:0] op, logic [15:0] a, logic [15:0] b);
    case (op)
      OP_ADD:  return 32'(a) + 32'(b);
      OP_MUL:  return 32'(a) * 32'(b);
      OP_DIV:  return b == 16'd0 ? 32'hFFFF_FFFF : {16'(a % b), 16'(a / b)};
      default: return {31'b0, a < b};
    endcase
  endfunction
  // ALU model: done rises lat(+random) edges after en is sampled, stays high until the next en
  always @(posedge clk or negedge nrst)
    if (!nrst) begin
      alu_done <= 1'b0; alu_res <= '0; pend <= '0; wcnt <= 0;
    end else if (alu_en) begin
      alu_done <= 1'b0;
      pend     <= ref_alu(alu_opcode, alu_opA, alu_opB);
      wcnt     <= lat < 0 ? lat : lat + int'($urandom_range(0, span));
    end else if (wcnt == 1) begin
      alu_done <= 1'b1; alu_res <= pend; wcnt <= 0; done_cyc <= cyc + 1;
    end else if (wcnt > 1) wcnt <= wcnt - 1;
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask
  function automatic int idx_of(logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction
  task automatic step();
    @(negedge clk);
    cyc++;
    if (|ack) begin
      chk("ack_onehot", $countones(ack), 1);
      ack_cyc.push_back(cyc); ack_idx.push_back(idx_of(ack));
    end
    if (alu_en) begin
      en_cyc.push_back(cyc); en_a.push_back(alu_opA); en_b.push_back(alu_opB); en_op.push_back(alu_opcode);
    end
    if (|rsp_valid) begin
      chk("rsp_onehot", $countones(rsp_valid), 1);
      rsp_cyc.push_back(cyc); rsp_idx.push_back(idx_of(rsp_valid));
      rsp_d.push_back(rsp_data); rsp_e.push_back(rsp_err);
    end else begin
      chk("rsp_data_idle", rsp_data, 0);
      chk("rsp_err_idle", {31'b0, rsp_err}, 0);
    end
    for (int i = 0; i < N; i++)
      if (ack[i] && !keep[i]) begin
        req[i] = 1'b0;
        req_opA[16*i +: 16] = 16'($urandom);
        req_opB[16*i +: 16] = 16'($urandom);
        req_opcode[2*i +: 2] = 2'($urandom);
      end
  endtask
  task automatic idle(int n);
    repeat (n) step();
  endtask
  task automatic clear_q();
    ack_cyc.delete(); ack_idx.delete(); en_cyc.delete(); en_a.delete(); en_b.delete();
    en_op.delete(); rsp_cyc.delete(); rsp_idx.delete(); rsp_d.delete(); rsp_e.delete();
  endtask
  task automatic set_req(int i, logic [1:0] op, logic [15:0] a, logic [15:0] b);
    req_opA[16*i +: 16] = a; req_opB[16*i +: 16] = b; req_opcode[2*i +: 2] = op;
    opa_m[i] = a; opb_m[i] = b; opc_m[i] = op; req[i] = 1'b1;
  endtask
  // predicts n grants from the current pending set, then runs and compares
  task automatic run_batch(int n, bit exp_err);
    logic [N-1:0] p;
    int w, t, c;
    int ex_i[$];
    logic [31:0] ex_d[$];
    p = req;
    t = 0;
    for (int k = 0; k < n; k++) begin
      w = -1;
      for (int j = 0; j < N; j++) begin
        c = (ptr_m + j) % N;
        if (w < 0 && p[c]) w = c;
      end
      if (w < 0) w = 0;
      ex_i.push_back(w);
      ex_d.push_back(exp_err ? 32'd0 : ref_alu(opc_m[w], opa_m[w], opb_m[w]));
      ptr_m = (w + 1) % N;
      if (!keep[w]) p[w] = 1'b0;
    end
    while (rsp_idx.size() < n && t < 3000) begin
      step(); t++;
    end
    chk("batch_complete", rsp_idx.size(), n);
    for (int k = 0; k < n && k < rsp_idx.size(); k++) begin
      chk("grant_idx", ack_idx[k], ex_i[k]);
      chk("rsp_idx", rsp_idx[k], ex_i[k]);
      chk("rsp_data", rsp_d[k], ex_d[k]);
      chk("rsp_err", {31'b0, rsp_e[k]}, {31'b0, exp_err});
      chk("alu_opA", en_a[k], opa_m[ex_i[k]]);
      chk("alu_opB", en_b[k], opb_m[ex_i[k]]);
      chk("alu_opcode", en_op[k], opc_m[ex_i[k]]);
      chk("ack_to_en", en_cyc[k], ack_cyc[k] + 1);
      if (k > 0) chk("rsp_to_next_ack", ack_cyc[k], rsp_cyc[k-1] + 2);
    end
  endtask
  initial begin
    idle(2);
    chk("rst_ack", ack, 0); chk("rst_rsp_valid", rsp_valid, 0); chk("rst_busy", busy, 0);
    chk("rst_alu_en", alu_en, 0); chk("rst_opA", alu_opA, 0); chk("rst_opB", alu_opB, 0);
    chk("rst_opcode", alu_opcode, 0);
    nrst = 1'b1;
    idle(1);
    clear_q(); n0 = cyc;
    set_req(0, OP_ADD, 16'd111, 16'd135);
    run_batch(1, 0);
    chk("t1_data", rsp_d[0], 32'h0000_00F6);
    chk("t1_req_to_ack", ack_cyc[0], n0 + 1);
    chk("t1_en_once", en_cyc.size(), 1);
    chk("t1_done_to_rsp", rsp_cyc[0], done_cyc + 1);
    idle(2);
    chk("t1_idle_busy", busy, 0);
    clear_q();
    set_req(1, OP_ADD, 16'd1, 16'd2);
    run_batch(1, 0);
    idle(2);
    for (int r = 0; r < 2; r++) begin
      clear_q();
      set_req(0, OP_MUL, 16'd135, 16'd111);
      set_req(1, OP_DIV, 16'h7EED, 16'h0105);
      run_batch(2, 0);
      chk("t2_first_is_0", rsp_idx[0], 0);
      chk("t2_mul", rsp_d[0], 32'h0000_3A89);
      idle(2);
    end
    clear_q(); keep = '1;
    set_req(0, OP_CMP, 16'd3, 16'd9);
    set_req(1, OP_ADD, 16'hFFFF, 16'hFFFF);
    run_batch(4, 0);
    req = '0; keep = '0;
    idle(4);
    chk("t3_third_is_0", ack_idx[2], 0);
    chk("t3_fourth_is_1", ack_idx[3], 1);
    chk("t3_no_extra", ack_idx.size(), 4);
    lat = -1; clear_q();
    set_req(0, OP_DIV, 16'd100, 16'd7);
    run_batch(1, 1);
    chk("t4_timeout_lat", rsp_cyc[0], en_cyc[0] + TO + 1);
    lat = 1; idle(2); clear_q();
    set_req(1, OP_MUL, 16'h0102, 16'h0304);
    run_batch(1, 0);
    idle(2);
    lat = 4; clear_q();
    set_req(0, OP_ADD, 16'h1234, 16'h1111);
    run_batch(1, 0);
    chk("t5_fresh_data", rsp_d[0], 32'h0000_2345);
    chk("t5_done_to_rsp", rsp_cyc[0], done_cyc + 1);
    idle(2);
    lat = 20; clear_q(); n0 = 0;
    set_req(0, OP_MUL, 16'd500, 16'd600);
    while (en_cyc.size() == 0 && n0 < 50) begin
      step(); n0++;
    end
    chk("t6_issued", en_cyc.size(), 1);
    idle(3);
    set_req(1, OP_ADD, 16'd7, 16'd8);
    nrst = 1'b0;
    #1;
    chk("t6_ack", ack, 0); chk("t6_rsp_valid", rsp_valid, 0); chk("t6_rsp_data", rsp_data, 0);
    chk("t6_busy", busy, 0); chk("t6_alu_en", alu_en, 0); chk("t6_opA", alu_opA, 0);
    chk("t6_opB", alu_opB, 0); chk("t6_opcode", alu_opcode, 0);
    idle(2);
    chk("t6_no_rsp", rsp_idx.size(), 0);
    nrst = 1'b1; ptr_m = 0; lat = 1; n0 = cyc; clear_q();
    run_batch(1, 0);
    chk("t6_ack_after_rst", ack_cyc[0], n0 + 1);
    idle(2);
    for (int r = 0; r < 30; r++) begin
      logic [N-1:0] s;
      s = N'($urandom_range(1, (1 << N) - 1));
      span = $urandom_range(0, 5);
      clear_q();
      for (int i = 0; i < N; i++)
        if (s[i]) set_req(i, 2'($urandom), 16'($urandom), 16'($urandom));
      run_batch($countones(s), 0);
      idle($urandom_range(1, 3));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one sequential ALU (16-bit operands, 2-bit opcode, en/done handshake, 32-bit result) between N_REQ requesters.
- Arbitrates requests round-robin, latches the winner's command, drives the ALU, waits for done, and returns the result to the winner.
- Adds a timeout guard so a hung ALU cannot block every requester.
- Sits between client blocks and the ALU instance; it is the only driver of the ALU's en/opA/opB/opcode.

Parameters:
- N_REQ, 2, number of requesters (2..4).
- TIMEOUT, 40, maximum cycles in WAIT before an error response; must exceed the worst-case div latency.
- CW, 6, timeout counter width; must satisfy 2^CW > TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge.
- nrst  in  1  asynchronous active-low reset.
- req  in  N_REQ  per-requester request level.
- req_opA  in  16*N_REQ  packed operand A, slot i = bits [16i+15:16i].
- req_opB  in  16*N_REQ  packed operand B.
- req_opcode  in  2*N_REQ  packed opcode.
- ack  out  N_REQ  one-hot, one-cycle pulse: command accepted.
- rsp_valid  out  N_REQ  one-hot, one-cycle pulse: response for requester i.
- rsp_data  out  32  result, valid while any rsp_valid is high.
- rsp_err  out  1  timeout flag, valid with rsp_valid.
- busy  out  1  high in every state except IDLE.
- alu_en  out  1  to ALU en.
- alu_opA  out  16  to ALU opA.
- alu_opB  out  16  to ALU opB.
- alu_opcode  out  2  to ALU opcode.
- alu_res  in  32  from ALU res.
- alu_done  in  1  from ALU done.

Behaviour:
- Clocking and reset: one clock domain. Reset is asynchronous and active-low.
- Reset values: state=IDLE, priority pointer=0, all outputs 0, latched command=0, timeout counter=0.
- ALU contract: the ALU samples en on a rising edge. It clears done on that edge. It holds done high with a valid res until the next en.

State machine (registered outputs):
- IDLE:
  - If any req is set, pick the first set bit searching from pointer upward, with wrap-around.
  - Latch that requester's opA/opB/opcode and its index.
  - Pulse ack[idx] for one cycle and go to ISSUE.
  - If no req is set, stay in IDLE.
- ISSUE:
  - alu_en=1 for exactly one cycle, with the latched operands on alu_opA/opB/opcode.
  - Clear the counter and go to WAIT.
- WAIT:
  - Hold alu_opA/opB/opcode stable; alu_en=0.
  - Ignore alu_done in the first WAIT cycle, because done may be stale.
  - From the second cycle: alu_done=1 → rsp_data=alu_res, rsp_err=0, go to RESP.
  - Otherwise increment the counter. When counter==TIMEOUT-1 and done is still 0 → rsp_data=0, rsp_err=1, go to RESP.
- RESP:
  - rsp_valid[idx]=1 for one cycle.
  - pointer = (idx+1) mod N_REQ, go to IDLE.
  - rsp_data and rsp_err clear to 0 on the next cycle.

Requester handshake:
- A requester holds req and its operands stable until it sees ack.
- It must drop req in the cycle after ack unless it is issuing a new command. A re-asserted req is queued by arbitration.
- Requests arriving while busy wait; they are not lost, because req is a level.
- Simultaneous requests: only one is granted per transaction. A losing requester keeps req high.

Fixed latencies:
- req to ack: 1 cycle when IDLE.
- ack to alu_en: 1 cycle.
- alu_done to rsp_valid: 1 cycle.
- RESP to next ack: minimum 1 cycle (one IDLE cycle).

Other rules:
- Widths: pass-through only. No arithmetic on data; the result is copied unmodified.
- Operand changes on req_* after ack must not affect the in-flight ALU command.
- Reset mid-operation returns the block immediately to reset values. No response is produced for the aborted command, and alu_en is forced to 0.

Decomposition:
- Package alu_pkg:
  - opcode constants: OP_ADD=2'b00, OP_MUL=2'b01, OP_DIV=2'b10, OP_CMP=2'b11.
  - state encoding: IDLE, ISSUE, WAIT, RESP.
- Sub-module rr_pick: combinational round-robin priority picker, taking req and pointer and producing a one-hot grant and the grant index.
- The FSM, latches and timeout counter stay in alu_arbiter.

Test Plan:
1. After reset, req[0]=1 with opA=111, opB=135, OP_ADD; ALU model done 1 cycle after en → ack[0] pulses, alu_en pulses once, then rsp_valid[0] with rsp_data=32'h000000F6, rsp_err=0.
2. req[0] and req[1] raised in the same cycle; req[0] = 135*111 OP_MUL, req[1] = 16'h7EED/16'h0105 OP_DIV → requester 0 served first with rsp_data=32'h00003A89, then requester 1. A second simultaneous pair is served 0 first again, because the pointer is 0 after serving 1.
3. Fairness: req[0] held permanently and req[1] asserted → grants strictly alternate 0,1,0,1.
4. ALU model never asserts done → rsp_valid pulses exactly TIMEOUT+1 cycles after alu_en, with rsp_err=1 and rsp_data=0. The next request then proceeds normally.
5. Stale done: the ALU model holds done=1 from the previous op and clears it one cycle late → the controller does not respond with the stale res.
6. nrst dropped mid-WAIT of an OP_MUL → all outputs 0 immediately and no rsp_valid. After release, a pending req[1] is acked one cycle later.
